stream_sel_mux: RTL and testbench

- Parametrised, registered N:1 pixel-stream multiplexer with valid/ready handshake and frame-aware channel switching; successor to the combinational 8:1 byte mux.
- Sits between multiple pixel sources (camera, test pattern, filter outputs) and a single downstream processing or display pipeline.
- A channel switch never cuts a frame: a requested select takes effect only on a frame boundary. A 2-entry output stage gives full throughput with registered outputs.

---
 rtl/stream_sel_mux.sv | 140 ++++++++++++++
 tb/tb_stream_sel_mux.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sel_mux.sv
// Registered N:1 pixel-stream multiplexer with valid/ready handshake.
// Channel switches are deferred to frame boundaries and cost one bubble cycle.
module stream_sel_mux #(
   parameter int NUM_CH     = 8,
   parameter int DATA_W     = 8,
   parameter int SEL_W      = 3,
   parameter int DROP_UNSEL = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   input  logic [NUM_CH-1:0]        s_valid,
   input  logic [NUM_CH-1:0]        s_last,
   output logic [NUM_CH-1:0]        s_ready,
   input  logic [SEL_W-1:0]         sel_req,
   input  logic                     sel_req_valid,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   output logic                     m_last,
   output logic [SEL_W-1:0]         m_ch,
   input  logic                     m_ready,
   output logic [SEL_W-1:0]         active_sel,
   output logic                     sel_err
);

   localparam logic           UNSEL_READY = (DROP_UNSEL != 0);
   localparam logic [SEL_W:0] CH_LIMIT    = (SEL_W+1)'(NUM_CH);

   logic [SEL_W-1:0]  pend_sel;
   logic              pend_vld;
   logic              in_frame;

   logic              main_vld;
   logic [DATA_W-1:0] main_data;
   logic              main_last;
   logic [SEL_W-1:0]  main_ch;

   logic              skid_vld;
   logic [DATA_W-1:0] skid_data;
   logic              skid_last;
   logic [SEL_W-1:0]  skid_ch;

   logic              act_valid;
   logic              act_last;
   logic [DATA_W-1:0] act_data;
   logic              act_ready;
   logic              switch_now;
   logic              accept;
   logic              req_ok;

   always_comb begin
      act_valid = 1'b0;
      act_last  = 1'b0;
      act_data  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (active_sel == SEL_W'(k)) begin
            act_valid = s_valid[k];
            act_last  = s_last[k];
            act_data  = s_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // switch_now looks only at registered state so s_ready never depends on inputs
   assign switch_now = pend_vld && !in_frame;
   assign act_ready  = !skid_vld && !switch_now;
   assign accept     = act_valid && act_ready;
   assign req_ok     = {1'b0, sel_req} < CH_LIMIT;

   always_comb begin
      s_ready = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         s_ready[k] = (active_sel == SEL_W'(k)) ? act_ready : UNSEL_READY;
      end
   end

   // A request arriving during the switch cycle overrides the clear of pend_vld
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_sel <= '0;
         pend_sel   <= '0;
         pend_vld   <= 1'b0;
         in_frame   <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         sel_err <= sel_req_valid && !req_ok;
         if (switch_now) begin
            active_sel <= pend_sel;
            pend_vld   <= 1'b0;
         end
         if (sel_req_valid && req_ok) begin
            pend_sel <= sel_req;
            pend_vld <= 1'b1;
         end
         if (accept) begin
            in_frame <= !act_last;
         end
      end
   end

   // Accept implies the skid is empty, so an accept never collides with a skid-to-main move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld  <= 1'b0;
         main_data <= '0;
         main_last <= 1'b0;
         main_ch   <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
         skid_ch   <= '0;
      end else if (accept) begin
         if (!main_vld || m_ready) begin
            main_vld  <= 1'b1;
            main_data <= act_data;
            main_last <= act_last;
            main_ch   <= active_sel;
         end else begin
            skid_vld  <= 1'b1;
            skid_data <= act_data;
            skid_last <= act_last;
            skid_ch   <= active_sel;
         end
      end else if (main_vld && m_ready) begin
         main_vld <= skid_vld;
         if (skid_vld) begin
            main_data <= skid_data;
            main_last <= skid_last;
            main_ch   <= skid_ch;
            skid_vld  <= 1'b0;
         end
      end
   end

   assign m_valid = main_vld;
   assign m_data  = main_data;
   assign m_last  = main_last;
   assign m_ch    = main_ch;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Bench for stream_sel_mux: a stalling and a draining instance share stimulus and
// are checked against a queue-based reference model plus directed expectations.
module tb_stream_sel_mux;

   localparam int NUM_CH = 6;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NUM_CH*DATA_W-1:0] s_data;
   logic [NUM_CH-1:0]        s_valid, s_last;
   logic [SEL_W-1:0]         sel_req;
   logic                     sel_req_valid, m_ready;

   logic [NUM_CH-1:0] s_ready0, s_ready1;
   logic [7:0]        m_data0, m_data1;
   logic              m_valid0, m_valid1, m_last0, m_last1, sel_err0, sel_err1;
   logic [2:0]        m_ch0, m_ch1, active_sel0, active_sel1;

   stream_sel_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .DROP_UNSEL(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready0), .sel_req(sel_req), .sel_req_valid(sel_req_valid),
      .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ch(m_ch0),
      .m_ready(m_ready), .active_sel(active_sel0), .sel_err(sel_err0));

   stream_sel_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .DROP_UNSEL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready1), .sel_req(sel_req), .sel_req_valid(sel_req_valid),
      .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ch(m_ch1),
      .m_ready(m_ready), .active_sel(active_sel1), .sel_err(sel_err1));

   logic [22:0] obs0, obs1, exp0, exp1;
   assign obs0 = {s_ready0, m_valid0, m_valid0 ? {m_ch0, m_last0, m_data0} : 12'h0, active_sel0, sel_err0};
   assign obs1 = {s_ready1, m_valid1, m_valid1 ? {m_ch1, m_last1, m_data1} : 12'h0, active_sel1, sel_err1};

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: output stage is a 2-deep queue of {ch, last, data}
   logic [11:0]       mq[$];
   logic [2:0]        m_act, m_psel;
   logic              m_pv, m_inf, m_err, m_sw, m_acc, m_rdy;
   logic [NUM_CH-1:0] rd0, rd1;
   logic [11:0]       hd;
   int                ma;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_act = 3'd0; m_psel = 3'd0; m_pv = 1'b0; m_inf = 1'b0; m_err = 1'b0;
         end else begin
            ma    = int'(m_act);
            m_sw  = m_pv && !m_inf;
            m_acc = s_valid[ma] && (mq.size() < 2) && !m_sw;
            if (mq.size() > 0 && m_ready) void'(mq.pop_front());
            if (m_acc) begin
               mq.push_back({m_act, s_last[ma], s_data[ma*8 +: 8]});
               m_inf = !s_last[ma];
            end
            if (m_sw) begin
               m_act = m_psel;
               m_pv  = 1'b0;
            end
            m_err = 1'b0;
            if (sel_req_valid) begin
               if (int'(sel_req) < NUM_CH) begin
                  m_psel = sel_req;
                  m_pv   = 1'b1;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
         m_rdy = (mq.size() < 2) && !(m_pv && !m_inf);
         rd0 = '0;
         rd1 = '1;
         rd0[m_act] = m_rdy;
         rd1[m_act] = m_rdy;
         hd = (mq.size() > 0) ? mq[0] : 12'h0;
         exp0 = {rd0, mq.size() > 0, hd, m_act, m_err};
         exp1 = {rd1, mq.size() > 0, hd, m_act, m_err};
      end
   end

   task automatic idle();
      s_valid = '0;
      s_last = '0;
      sel_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      s_data = '0; sel_req = '0; m_ready = 1'b0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL reset_model0 got %h want %h", obs0, exp0); end
      n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL reset_model1 got %h want %h", obs1, exp1); end
      n_cmp++;
      if ({m_valid0, m_data0, m_last0, m_ch0, active_sel0, sel_err0} !== 15'h0) begin
         n_err++; $display("FAIL reset_outputs got v=%b d=%h l=%b ch=%0d act=%0d err=%b want all zero",
                           m_valid0, m_data0, m_last0, m_ch0, active_sel0, sel_err0);
      end
      n_cmp++; if (s_ready0 !== 6'b000001) begin n_err++; $display("FAIL reset_ready0 got %b want 000001", s_ready0); end
      n_cmp++; if (s_ready1 !== 6'b111111) begin n_err++; $display("FAIL reset_ready1 got %b want 111111", s_ready1); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 6; i++) begin
         idle(); m_ready = 1'b1;
         if (i < 4) begin
            s_valid[0] = 1'b1; s_data[7:0] = 8'(8'h10 + i); s_last[0] = (i == 3);
         end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL basic_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL basic_model1 i=%0d got %h want %h", i, obs1, exp1); end
         if (i >= 1 && i <= 4) begin
            n_cmp++;
            if (!(m_valid0 === 1'b1 && m_data0 === 8'(8'h10 + i - 1) && m_last0 === (i == 4) && m_ch0 === 3'd0)) begin
               n_err++; $display("FAIL basic_beat i=%0d got v=%b d=%h l=%b ch=%0d want v=1 d=%h l=%b ch=0",
                                 i, m_valid0, m_data0, m_last0, m_ch0, 8'(8'h10 + i - 1), (i == 4));
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_midframe_switch();
      logic [10:0] seen[$];
      for (int i = 0; i < 10; i++) begin
         idle(); m_ready = 1'b1;
         if (i < 6) begin
            s_valid[0] = 1'b1; s_data[7:0] = 8'(8'h20 + i); s_last[0] = (i == 5);
         end
         if (i == 2) begin sel_req = 3'd3; sel_req_valid = 1'b1; end
         if (i == 6 || i == 7) begin
            s_valid[3] = 1'b1; s_data[31:24] = 8'hA0; s_last[3] = 1'b1;
         end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL switch_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL switch_model1 i=%0d got %h want %h", i, obs1, exp1); end
         if (i == 6) begin
            n_cmp++; if (s_ready0 !== 6'b000000) begin n_err++; $display("FAIL switch_bubble_ready0 got %b want 000000", s_ready0); end
            n_cmp++; if (s_ready1 !== 6'b111110) begin n_err++; $display("FAIL switch_bubble_ready1 got %b want 111110", s_ready1); end
         end
         if (i == 7) begin
            n_cmp++; if (m_valid0 !== 1'b0) begin n_err++; $display("FAIL switch_out_bubble got %b want 0", m_valid0); end
         end
         if (m_valid0 === 1'b1) seen.push_back({m_ch0, m_data0});
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen.size() != 7) begin
         n_err++; $display("FAIL switch_count got %0d want 7", seen.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            if (seen[k] !== ((k < 6) ? {3'd0, 8'(8'h20 + k)} : {3'd3, 8'hA0})) begin
               n_err++; $display("FAIL switch_seq k=%0d got %h", k, seen[k]);
            end
         end
      end
      n_cmp++; if (active_sel0 !== 3'd3) begin n_err++; $display("FAIL switch_active got %0d want 3", active_sel0); end
   endtask

   task automatic test_backpressure();
      logic [7:0] rcv[$];
      int  nxt = 0;
      bit  stalled = 0;
      bit  pat[5] = '{1, 0, 0, 1, 1};
      for (int i = 0; i < 45; i++) begin
         idle();
         m_ready = (i < 30) ? pat[i % 5] : 1'b1;
         if (nxt < 20) begin
            s_valid[3] = 1'b1; s_data[31:24] = 8'(8'h40 + nxt); s_last[3] = (nxt == 19);
         end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL bp_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL bp_model1 i=%0d got %h want %h", i, obs1, exp1); end
         if (s_ready0[3] === 1'b0) stalled = 1;
         if (m_valid0 === 1'b1 && m_ready) rcv.push_back(m_data0);
         if (s_valid[3] && s_ready0[3] === 1'b1) nxt++;
         @(posedge clk); #1;
      end
      n_cmp++; if (!stalled) begin n_err++; $display("FAIL bp_stall got no stall want stall"); end
      n_cmp++;
      if (rcv.size() != 20) begin
         n_err++; $display("FAIL bp_count got %0d want 20", rcv.size());
      end else begin
         for (int k = 0; k < 20; k++) begin
            if (rcv[k] !== 8'(8'h40 + k)) begin
               n_err++; $display("FAIL bp_seq k=%0d got %h want %h", k, rcv[k], 8'(8'h40 + k));
            end
         end
      end
   endtask

   task automatic test_sel_err();
      for (int i = 0; i < 4; i++) begin
         idle(); m_ready = 1'b1;
         if (i == 0) begin sel_req = 3'd7; sel_req_valid = 1'b1; end
         if (i == 1) begin sel_req = 3'd6; sel_req_valid = 1'b1; end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL err_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (sel_err0 !== (i == 1 || i == 2)) begin n_err++; $display("FAIL err_pulse i=%0d got %b want %b", i, sel_err0, (i == 1 || i == 2)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (active_sel0 !== 3'd3) begin n_err++; $display("FAIL err_active got %0d want 3", active_sel0); end
      n_cmp++; if (s_ready0 !== 6'b001000) begin n_err++; $display("FAIL err_no_pending got %b want 001000", s_ready0); end
   endtask

   task automatic test_two_requests();
      for (int i = 0; i < 9; i++) begin
         idle(); m_ready = 1'b1;
         if (i < 5) begin
            s_valid[3] = 1'b1; s_data[31:24] = 8'(8'h60 + i); s_last[3] = (i == 4);
         end
         if (i == 1) begin sel_req = 3'd5; sel_req_valid = 1'b1; end
         if (i == 3) begin sel_req = 3'd2; sel_req_valid = 1'b1; end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL two_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL two_model1 i=%0d got %h want %h", i, obs1, exp1); end
         n_cmp++; if (active_sel0 === 3'd5 || (m_valid0 && m_ch0 === 3'd5)) begin n_err++; $display("FAIL two_ch5_routed i=%0d got act=%0d ch=%0d want never 5", i, active_sel0, m_ch0); end
         if (i == 5) begin
            n_cmp++; if (s_ready1 !== 6'b110111) begin n_err++; $display("FAIL two_bubble got %b want 110111", s_ready1); end
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (active_sel0 !== 3'd2) begin n_err++; $display("FAIL two_active got %0d want 2", active_sel0); end
   endtask

   task automatic test_drop_unsel();
      for (int i = 0; i < 5; i++) begin
         idle(); m_ready = 1'b1;
         s_valid[1] = 1'b1; s_data[15:8] = 8'hEE; s_last[1] = 1'b0;
         if (i < 4) begin
            s_valid[2] = 1'b1; s_data[23:16] = 8'(8'h70 + i); s_last[2] = (i == 3);
         end
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL drop_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL drop_model1 i=%0d got %h want %h", i, obs1, exp1); end
         n_cmp++; if (s_ready1[1] !== 1'b1 || s_ready0[1] !== 1'b0) begin n_err++; $display("FAIL drop_ready1 i=%0d got d1=%b d0=%b want d1=1 d0=0", i, s_ready1[1], s_ready0[1]); end
         if (i >= 1) begin
            n_cmp++;
            if (!(m_valid1 === 1'b1 && m_data1 === 8'(8'h70 + i - 1) && m_ch1 === 3'd2)) begin
               n_err++; $display("FAIL drop_out i=%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=2",
                                 i, m_valid1, m_data1, m_ch1, 8'(8'h70 + i - 1));
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 3; i++) begin
         idle(); m_ready = 1'b0;
         if (i < 2) begin
            s_valid[2] = 1'b1; s_data[23:16] = 8'(8'h80 + i); s_last[2] = 1'b0;
         end
         @(negedge clk);
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++; if (m_valid0 !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %b want 1", m_valid0); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b%b want 00", m_valid0, m_valid1); end
      n_cmp++; if (active_sel0 !== 3'd0 || active_sel1 !== 3'd0) begin n_err++; $display("FAIL rstmid_active got %0d/%0d want 0", active_sel0, active_sel1); end
      n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL rstmid_model0 got %h want %h", obs0, exp0); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         s_valid       = 6'($urandom);
         s_last        = 6'($urandom & $urandom);
         s_data        = 48'({$urandom, $urandom});
         sel_req       = 3'($urandom);
         sel_req_valid = ($urandom % 12) == 0;
         m_ready       = ($urandom % 4) != 0;
         @(negedge clk);
         n_cmp++; if (obs0 !== exp0) begin n_err++; $display("FAIL rand_model0 i=%0d got %h want %h", i, obs0, exp0); end
         n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL rand_model1 i=%0d got %h want %h", i, obs1, exp1); end
         @(posedge clk); #1;
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_midframe_switch();
      test_backpressure();
      test_sel_err();
      test_two_requests();
      test_drop_unsel();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
